// File: rtl/edge_event_arbiter.sv
// Turns N level request lines into sticky rising-edge events and shares one engine between them
// round-robin. Define EDGE_EVENT_TIMEOUT_EN to add the BUSY watchdog (timeout_err pulse).
module edge_event_arbiter #(
   parameter int N_REQ = 4,
`ifdef EDGE_EVENT_TIMEOUT_EN
   parameter int TO_WIDTH = 16,
   parameter int TO_CYCLES = 1000,
`endif
   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_sig,
   input  logic             eng_done,
   output logic             eng_start,
   output logic [SEL_W-1:0] eng_sel,
   output logic             busy,
   output logic [N_REQ-1:0] pending,
   output logic             overflow,
   output logic             timeout_err
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] req_dly_q;
   logic             done_dly_q;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic             overflow_q, overflow_d;

   logic [N_REQ-1:0] req_edge;
   logic             done_edge;
   logic [N_REQ-1:0] grant_vec;
   logic [SEL_W-1:0] winner;
   logic [SEL_W-1:0] cand;
   logic             found;
   int               search_idx;

`ifdef EDGE_EVENT_TIMEOUT_EN
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_CYCLES - 1);
   logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
   logic                timeout_q, timeout_d;
`endif

   // Delay registers reset to ones, so a line already high at reset release is not an event.
   assign req_edge  = req_sig & ~req_dly_q;
   assign done_edge = eng_done & ~done_dly_q;

   // Round-robin search: first pending bit at or after the pointer, wrapping at N_REQ.
   always_comb begin
      found      = 1'b0;
      winner     = ptr_q;
      search_idx = 0;
      cand       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         search_idx = (int'(ptr_q) + i) % N_REQ;
         cand       = SEL_W'(search_idx);
         if (!found && pending_q[cand]) begin
            found  = 1'b1;
            winner = cand;
         end else begin
            found = found;
         end
      end
   end

   // Next-state logic for the FSM, pending bits and registered outputs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      start_d   = 1'b0;
      grant_vec = '0;
`ifdef EDGE_EVENT_TIMEOUT_EN
      wd_cnt_d  = wd_cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_vec[winner] = 1'b1;
               sel_d             = winner;
               start_d           = 1'b1;
               state_d           = S_BUSY;
               ptr_d             = (winner == SEL_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
`ifdef EDGE_EVENT_TIMEOUT_EN
               wd_cnt_d          = '0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            // A done edge wins over watchdog expiry on the same cycle.
            if (done_edge) begin
               state_d = S_IDLE;
`ifdef EDGE_EVENT_TIMEOUT_EN
            end else if (wd_cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
`else
            end else begin
               state_d = S_BUSY;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      pending_d  = (pending_q & ~grant_vec) | req_edge;
      overflow_d = |(req_edge & pending_q & ~grant_vec);
      busy_d     = (state_d == S_BUSY);
   end

   // Core state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         req_dly_q  <= '1;
         done_dly_q <= 1'b1;
         pending_q  <= '0;
         ptr_q      <= '0;
         sel_q      <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_dly_q  <= req_sig;
         done_dly_q <= eng_done;
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef EDGE_EVENT_TIMEOUT_EN
   // Watchdog counter and its error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign eng_start = start_q;
   assign eng_sel   = sel_q;
   assign busy      = busy_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter; snapshot = {eng_start, eng_sel, busy, pending, overflow, timeout_err}.
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_sig;
   logic       eng_done;
   logic       eng_start;
   logic [1:0] eng_sel;
   logic       busy;
   logic [3:0] pending;
   logic       overflow;
   logic       timeout_err;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp;
   logic [9:0] snap;

   assign snap = {eng_start, eng_sel, busy, pending, overflow, timeout_err};

   always #5 clk = ~clk;

`ifdef EDGE_EVENT_TIMEOUT_EN
   edge_event_arbiter #(.N_REQ(4), .TO_WIDTH(16), .TO_CYCLES(8)) dut (
`else
   edge_event_arbiter #(.N_REQ(4)) dut (
`endif
      .clk(clk), .rst(rst), .req_sig(req_sig), .eng_done(eng_done),
      .eng_start(eng_start), .eng_sel(eng_sel), .busy(busy), .pending(pending),
      .overflow(overflow), .timeout_err(timeout_err)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1; req_sig = 4'b0000; eng_done = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; req_sig = 4'b0010; eng_done = 1'b0;
      step(); step();
      exp = {1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL reset_values: got %b expected %b", snap, exp); end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         exp = {1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
         if (snap !== exp) begin errors++; $display("FAIL held_high_no_event: got %b expected %b", snap, exp); end
      end
      req_sig = 4'b0000; step();
      req_sig = 4'b0010; step();
      exp = {1'b0, 2'd0, 1'b0, 4'b0010, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL reset_rearm_pending: got %b expected %b", snap, exp); end
      step();
      exp = {1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL reset_rearm_start: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      exp = {1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL reset_rearm_done: got %b expected %b", snap, exp); end
      eng_done = 1'b0; step();
   endtask

   task automatic test_single();
      req_sig = 4'b0110; step();
      exp = {1'b0, 2'd1, 1'b0, 4'b0100, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL single_pending: got %b expected %b", snap, exp); end
      step();
      exp = {1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL single_start: got %b expected %b", snap, exp); end
      step();
      exp = {1'b0, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL single_start_one_cycle: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      exp = {1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL single_done: got %b expected %b", snap, exp); end
      eng_done = 1'b0; step();
      exp = {1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL single_idle_after: got %b expected %b", snap, exp); end
   endtask

   task automatic test_round_robin();
      logic [3:0] pend;
      apply_reset();
      req_sig = 4'b1111; step();
      exp = {1'b0, 2'd0, 1'b0, 4'b1111, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL rr_all_pending: got %b expected %b", snap, exp); end
      step();
      pend = 4'b1110;
      exp = {1'b1, 2'd0, 1'b1, pend, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL rr_grant0: got %b expected %b", snap, exp); end
      for (int g = 1; g < 4; g++) begin
         eng_done = 1'b1; step();
         exp = {1'b0, 2'(g - 1), 1'b0, pend, 1'b0, 1'b0}; checks++;
         if (snap !== exp) begin errors++; $display("FAIL rr_done_%0d: got %b expected %b", g - 1, snap, exp); end
         eng_done = 1'b0; step();
         pend[g] = 1'b0;
         exp = {1'b1, 2'(g), 1'b1, pend, 1'b0, 1'b0}; checks++;
         if (snap !== exp) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, snap, exp); end
      end
      eng_done = 1'b1; step();
      eng_done = 1'b0; req_sig = 4'b0000; step();
      exp = {1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL rr_drained: got %b expected %b", snap, exp); end
      req_sig = 4'b1001; step();
      exp = {1'b0, 2'd3, 1'b0, 4'b1001, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL rr_wrap_pending: got %b expected %b", snap, exp); end
      step();
      exp = {1'b1, 2'd0, 1'b1, 4'b1000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL rr_wrap_grant0: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      eng_done = 1'b0; step();
      exp = {1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL rr_wrap_grant3: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      eng_done = 1'b0; step();
   endtask

   task automatic test_overflow();
      apply_reset();
      req_sig = 4'b0001; step(); step();
      exp = {1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL ovf_grant0: got %b expected %b", snap, exp); end
      req_sig = 4'b0011; step();
      exp = {1'b0, 2'd0, 1'b1, 4'b0010, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL ovf_first_event: got %b expected %b", snap, exp); end
      req_sig = 4'b0001; step();
      req_sig = 4'b0011; step();
      exp = {1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL ovf_pulse: got %b expected %b", snap, exp); end
      step();
      exp = {1'b0, 2'd0, 1'b1, 4'b0010, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL ovf_single_cycle: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      eng_done = 1'b0; step();
      exp = {1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL ovf_grant1: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      eng_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         exp = {1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
         if (snap !== exp) begin errors++; $display("FAIL ovf_no_second_start: got %b expected %b", snap, exp); end
      end
   endtask

   task automatic test_done_level();
      apply_reset();
      req_sig = 4'b0011; step(); step();
      exp = {1'b1, 2'd0, 1'b1, 4'b0010, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL lvl_grant0: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      exp = {1'b0, 2'd0, 1'b0, 4'b0010, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL lvl_done0: got %b expected %b", snap, exp); end
      step();
      exp = {1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL lvl_grant1: got %b expected %b", snap, exp); end
      for (int i = 0; i < 3; i++) begin
         step();
         exp = {1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
         if (snap !== exp) begin errors++; $display("FAIL lvl_held_still_busy: got %b expected %b", snap, exp); end
      end
      eng_done = 1'b0; step();
      eng_done = 1'b1; step();
      exp = {1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL lvl_fresh_edge: got %b expected %b", snap, exp); end
      eng_done = 1'b0; step();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      req_sig = 4'b0100; step(); step();
      exp = {1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL b2b_grant2: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      exp = {1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL b2b_done_with_start: got %b expected %b", snap, exp); end
      eng_done = 1'b0; req_sig = 4'b0110; step(); step();
      exp = {1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL b2b_ptr_wrap_grant1: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      eng_done = 1'b0; step();
   endtask

   task automatic test_timeout();
      apply_reset();
      req_sig = 4'b0101; step(); step();
      exp = {1'b1, 2'd0, 1'b1, 4'b0100, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL to_grant0: got %b expected %b", snap, exp); end
      for (int i = 1; i < 8; i++) begin
         step();
         exp = {1'b0, 2'd0, 1'b1, 4'b0100, 1'b0, 1'b0}; checks++;
         if (snap !== exp) begin errors++; $display("FAIL to_wait_%0d: got %b expected %b", i, snap, exp); end
      end
      step();
`ifdef EDGE_EVENT_TIMEOUT_EN
      exp = {1'b0, 2'd0, 1'b0, 4'b0100, 1'b0, 1'b1}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL to_expire: got %b expected %b", snap, exp); end
      step();
      exp = {1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL to_next_grant: got %b expected %b", snap, exp); end
`else
      exp = {1'b0, 2'd0, 1'b1, 4'b0100, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL to_disabled_busy: got %b expected %b", snap, exp); end
      for (int i = 0; i < 4; i++) step();
      exp = {1'b0, 2'd0, 1'b1, 4'b0100, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL to_disabled_still_busy: got %b expected %b", snap, exp); end
      eng_done = 1'b1; step();
      eng_done = 1'b0; step();
      exp = {1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0}; checks++;
      if (snap !== exp) begin errors++; $display("FAIL to_disabled_next_grant: got %b expected %b", snap, exp); end
`endif
      eng_done = 1'b1; step();
      eng_done = 1'b0; step();
   endtask

   initial begin
      rst = 1'b1; req_sig = 4'b0000; eng_done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_done_level();
      test_back_to_back();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
